// File: rtl/updi_pkg.sv
// Shared definitions for the UPDI transmitter and receiver: frame constants and FSM state encoding.
package updi_pkg;

    localparam int UPDI_DATA_BITS  = 8;
    localparam int UPDI_STOP_BITS  = 2;
    localparam int UPDI_FRAME_BITS = 1 + UPDI_DATA_BITS + 1 + UPDI_STOP_BITS;
    localparam int UPDI_IDX_W      = $clog2(UPDI_DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } updi_state_t;

endpackage

// File: rtl/updi_bit_timer.sv
// UART bit-period down-counter: load sets BIT_CLK-1, tick marks the last cycle of a bit.
module updi_bit_timer #(
    parameter int BIT_CLK = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic tick
);

    localparam int W = (BIT_CLK > 1) ? $clog2(BIT_CLK) : 1;

    logic [W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= W'(BIT_CLK - 1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/updi_tx.sv
// UPDI transmitter: 12-bit frames (start, 8 data LSB first, even parity, 2 stops) with break override.
module updi_tx
    import updi_pkg::*;
#(
    parameter int BIT_CLK = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       brk_busy,
    input  logic       brk_pulse,
    output logic       txd,
    output logic       tx_oe,
    output logic       busy
);

    updi_state_t                 state_q, state_d;
    logic [UPDI_DATA_BITS-1:0]   data_q;
    logic                        parity_q;
    logic [UPDI_IDX_W-1:0]       bit_idx_q;
    logic                        tick;
    logic                        load;
    logic                        accept;
    logic                        last_bit;

    assign tx_ready = (state_q == IDLE) && !brk_busy;
    assign accept   = tx_valid && tx_ready;
    assign busy     = (state_q != IDLE);
    assign last_bit = (bit_idx_q == UPDI_IDX_W'(UPDI_DATA_BITS - 1));

    updi_bit_timer #(
        .BIT_CLK (BIT_CLK)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .clear (brk_busy),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        if (brk_busy) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        state_d = START;
                        load    = 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state_d = DATA;
                        load    = 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        load = 1'b1;
                        if (last_bit) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state_d = STOP1;
                        load    = 1'b1;
                    end
                end
                STOP1: begin
                    if (tick) begin
                        state_d = STOP2;
                        load    = 1'b1;
                    end
                end
                STOP2: begin
                    if (tick) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Byte and parity are captured only on the handshake; later tx_data changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            parity_q  <= 1'b0;
            bit_idx_q <= '0;
        end else if (brk_busy) begin
            bit_idx_q <= '0;
        end else if (accept) begin
            data_q    <= tx_data;
            parity_q  <= ^tx_data;
            bit_idx_q <= '0;
        end else if (state_q == DATA && tick) begin
            bit_idx_q <= bit_idx_q + UPDI_IDX_W'(1);
        end
    end

    always_comb begin
        txd   = 1'b1;
        tx_oe = 1'b0;
        if (brk_busy) begin
            txd   = brk_pulse;
            tx_oe = 1'b1;
        end else begin
            case (state_q)
                START: begin
                    txd   = 1'b0;
                    tx_oe = 1'b1;
                end
                DATA: begin
                    txd   = data_q[bit_idx_q];
                    tx_oe = 1'b1;
                end
                PARITY: begin
                    txd   = parity_q;
                    tx_oe = 1'b1;
                end
                STOP1, STOP2: begin
                    txd   = 1'b1;
                    tx_oe = 1'b1;
                end
                default: begin
                    txd   = 1'b1;
                    tx_oe = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updi_tx.sv
// Directed bench for updi_tx at BIT_CLK = 4: frame table plus break, back-to-back and reset sequences.
module tb_updi_tx;
    import updi_pkg::*;

    localparam int BC = 4;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       brk_busy;
    logic       brk_pulse;
    logic       txd;
    logic       tx_oe;
    logic       busy;

    int checks;
    int errors;

    typedef struct packed {
        logic [7:0]  data;
        logic [11:0] frame;   // frame bit 0 is sent first
    } vec_t;

    vec_t vecs [6];

    updi_tx #(
        .BIT_CLK (BC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .brk_busy  (brk_busy),
        .brk_pulse (brk_pulse),
        .txd       (txd),
        .tx_oe     (tx_oe),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observed word is {txd, tx_oe, busy, tx_ready}.
    task automatic check_idle(input string name);
        @(negedge clk);
        check(name, {28'd0, txd, tx_oe, busy, tx_ready}, 32'b1001);
    endtask

    task automatic check_idle_span(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if ({txd, tx_oe, busy, tx_ready} !== 4'b1001) bad++;
        end
        check(name, bad, 0);
    endtask

    task automatic send_start(input logic [7:0] d, input string name);
        @(posedge clk); #1;
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        check({name, " handshake"}, {31'd0, tx_ready}, 32'd1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = ~d;
    endtask

    task automatic check_frame(input logic [11:0] frame, input string name);
        for (int k = 0; k < UPDI_FRAME_BITS * BC; k++) begin
            @(negedge clk);
            check($sformatf("%s cyc%0d", name, k + 1),
                  {28'd0, txd, tx_oe, busy, tx_ready},
                  {28'd0, frame[k / BC], 1'b1, 1'b1, 1'b0});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        brk_busy  = 1'b0;
        brk_pulse = 1'b0;

        vecs[0] = '{data: 8'h55, frame: 12'hCAA};
        vecs[1] = '{data: 8'h07, frame: 12'hE0E};
        vecs[2] = '{data: 8'h00, frame: 12'hC00};
        vecs[3] = '{data: 8'hFF, frame: 12'hDFE};
        vecs[4] = '{data: 8'h80, frame: 12'hF00};
        vecs[5] = '{data: 8'h3C, frame: 12'hC78};

        // Reset state, then break priority while still in reset.
        repeat (3) @(posedge clk);
        check_idle("reset idle");
        @(posedge clk); #1;
        brk_busy = 1'b1;
        @(negedge clk);
        check("reset with break", {28'd0, txd, tx_oe, busy, tx_ready}, 32'b0100);
        @(posedge clk); #1;
        brk_busy = 1'b0;
        rst      = 1'b0;
        check_idle("post reset idle");

        // Table of single frames.
        for (int v = 0; v < 6; v++) begin
            send_start(vecs[v].data, $sformatf("vec%0d", v));
            check_frame(vecs[v].frame, $sformatf("vec%0d", v));
            check_idle($sformatf("vec%0d end idle", v));
        end

        // Back-to-back with tx_valid held: one idle cycle, second start 49 cycles after handshake.
        @(posedge clk); #1;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        check("b2b handshake1", {31'd0, tx_ready}, 32'd1);
        @(posedge clk); #1;
        tx_data = 8'h3C;
        check_frame(12'hD4A, "b2b A5");
        check_idle("b2b gap cycle49");
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        check_frame(12'hC78, "b2b 3C");
        check_idle("b2b end idle");

        // Break at cycle 20 of a frame aborts it.
        send_start(8'h55, "brk");
        repeat (19) @(posedge clk);
        #1;
        brk_busy  = 1'b1;
        brk_pulse = 1'b0;
        @(negedge clk);
        check("brk cyc20", {28'd0, txd, tx_oe, busy, tx_ready}, 32'b0110);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            brk_pulse = i[0];
            @(negedge clk);
            check($sformatf("brk follow%0d", i), {28'd0, txd, tx_oe, busy, tx_ready},
                  {28'd0, i[0], 3'b100});
        end
        @(posedge clk); #1;
        brk_busy  = 1'b0;
        brk_pulse = 1'b0;
        check_idle("brk release idle");
        check_idle_span("brk no residual frame", 60);

        // tx_valid held during break: accepted on the first cycle after break falls.
        @(posedge clk); #1;
        brk_busy  = 1'b1;
        brk_pulse = 1'b1;
        tx_valid  = 1'b1;
        tx_data   = 8'h07;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("brk hold no accept%0d", i), {28'd0, txd, tx_oe, busy, tx_ready},
                  32'b1100);
        end
        @(posedge clk); #1;
        brk_busy  = 1'b0;
        brk_pulse = 1'b0;
        @(negedge clk);
        check("brk fall ready", {28'd0, txd, tx_oe, busy, tx_ready}, 32'b1001);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = 8'hF8;
        check_frame(12'hE0E, "post brk 07");
        check_idle("post brk end idle");

        // Reset at cycle 10 of a frame abandons it immediately.
        send_start(8'h55, "rst");
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst abort idle", {28'd0, txd, tx_oe, busy, tx_ready}, 32'b1001);
        check_idle_span("rst no residual frame", 50);

        send_start(8'hFF, "recover");
        check_frame(12'hDFE, "recover FF");
        check_idle("recover end idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
